// File: rtl/array_22_arbiter_if.sv
// Request/response and SRAM-side bundle for the two-requester SRAM arbiter.
// slave = arbiter side; master = client logic plus the SRAM macro model.
interface array_22_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wmode;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wmode;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp0_valid;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req0_valid, req0_wmode, req0_addr, req0_wdata,
        input  req1_valid, req1_wmode, req1_addr, req1_wdata,
        input  sram_rdata,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        output init_done, sram_en, sram_wmode, sram_addr, sram_wdata
    );

    modport master (
        output req0_valid, req0_wmode, req0_addr, req0_wdata,
        output req1_valid, req1_wmode, req1_addr, req1_wdata,
        output sram_rdata,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        input  init_done, sram_en, sram_wmode, sram_addr, sram_wdata
    );
endinterface

// File: rtl/array_22_arbiter.sv
// Zero-fill initializer and round-robin two-requester arbiter for a single-port
// 1-cycle-latency SRAM macro.
//
// state  | meaning
// S_INIT | sweeping every entry to zero, requests blocked
// S_RUN  | round-robin arbitration between req0 and req1
module array_22_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 256,
    parameter bit INIT_EN = 1'b1
) (
    input logic               RW0_clk,
    input logic               rst,
    array_22_arbiter_if.slave bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_STATE = INIT_EN ? S_INIT : S_RUN;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_grant;
    logic              init_done;
    logic              resp0_valid, resp1_valid;

    logic              gnt0, gnt1;
    logic              sram_en, sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;

    always_ff @(posedge RW0_clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_STATE;
            init_cnt    <= '0;
            last_grant  <= 1'b1;
            init_done   <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == S_RUN);
            // DEPTH == 2**ADDR_W, so the last increment wraps the counter to 0
            if (state == S_INIT)
                init_cnt <= init_cnt + ADDR_W'(1);
            if (gnt0)
                last_grant <= 1'b0;
            else if (gnt1)
                last_grant <= 1'b1;
            resp0_valid <= gnt0 & ~bus.req0_wmode;
            resp1_valid <= gnt1 & ~bus.req1_wmode;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_cnt == LAST_ADDR)
            state_nxt = S_RUN;
    end

    // rst gates the combinational drive so the macro sees no access while reset is held
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = init_cnt;
                end
                S_RUN: begin
                    gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
                    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
                    if (gnt0) begin
                        sram_en    = 1'b1;
                        sram_wmode = bus.req0_wmode;
                        sram_addr  = bus.req0_addr;
                        sram_wdata = bus.req0_wdata;
                    end else if (gnt1) begin
                        sram_en    = 1'b1;
                        sram_wmode = bus.req1_wmode;
                        sram_addr  = bus.req1_addr;
                        sram_wdata = bus.req1_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.resp0_valid = resp0_valid;
    assign bus.resp1_valid = resp1_valid;
    assign bus.resp_data   = bus.sram_rdata;
    assign bus.init_done   = init_done;
    assign bus.sram_en     = sram_en;
    assign bus.sram_wmode  = sram_wmode;
    assign bus.sram_addr   = sram_addr;
    assign bus.sram_wdata  = sram_wdata;
endmodule
